bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter in front of the Bridge data bus.
- Shares the single Bus_addr/Bus_wen/Bus_wdata/Bus_rdata port between the CPU load/store path (M0) and a second master (M1, DMA/debug loader).
- Round-robin grant, per-transfer req/ack handshake, fixed slave latency set by parameter; one transfer in flight at a time.

---
 rtl/bus_arbiter.sv | 121 ++++++++++++
 tb/tb_bus_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter for the Bridge data bus
// One transfer in flight; fixed slave latency LAT; registered bus and ack outputs.
module bus_arbiter #(
  parameter int LAT = 1,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_wen,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_wen,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic [AW-1:0] Bus_addr,
  output logic          Bus_wen,
  output logic [DW-1:0] Bus_wdata,
  input  logic [DW-1:0] Bus_rdata,
  output logic          busy,
  output logic          gnt_id
);

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_ACK} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t        state_q;
  logic          prio_q;
  logic [3:0]    cnt_q;
  logic [DW-1:0] rdata_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          wen_q;
  logic          busy_q;
  logic          gnt_q;
  logic          m0_ack_q;
  logic          m1_ack_q;

  // A lone requester wins regardless of prio; prio only breaks ties.
  logic          gnt_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic          wen_d;

  assign gnt_d   = (m0_req && m1_req) ? prio_q : m1_req;
  assign addr_d  = gnt_d ? m1_addr  : m0_addr;
  assign wdata_d = gnt_d ? m1_wdata : m0_wdata;
  assign wen_d   = gnt_d ? m1_wen   : m0_wen;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      prio_q   <= 1'b0;
      cnt_q    <= 4'd0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      busy_q   <= 1'b0;
      gnt_q    <= 1'b0;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          // Single write strobe: cleared on the first XFER edge for any LAT.
          wen_q <= 1'b0;
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rdata_q  <= Bus_rdata;
            m0_ack_q <= ~gnt_q;
            m1_ack_q <= gnt_q;
            state_q  <= ST_ACK;
          end
        end
        ST_ACK: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          prio_q   <= ~gnt_q;
          addr_q   <= '0;
          wdata_q  <= '0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Bus_addr  = addr_q;
  assign Bus_wdata = wdata_q;
  assign Bus_wen   = wen_q;
  assign busy      = busy_q;
  assign gnt_id    = gnt_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_ack_q ? rdata_q : '0;
  assign m1_rdata  = m1_ack_q ? rdata_q : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter (LAT=1 and LAT=3 instances)
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;

  logic        m0_req[2], m1_req[2], m0_wen[2], m1_wen[2];
  logic [31:0] m0_addr[2], m1_addr[2], m0_wdata[2], m1_wdata[2], bus_rdata[2];
  logic [31:0] m0_rdata_o[2], m1_rdata_o[2], bus_addr_o[2], bus_wdata_o[2];
  logic        m0_ack_o[2], m1_ack_o[2], bus_wen_o[2], busy_o[2], gnt_o[2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_arbiter #(.LAT(1), .AW(32), .DW(32)) u_lat1 (
    .clk_i(clk), .rst_i(rst_n),
    .m0_req(m0_req[0]), .m0_addr(m0_addr[0]), .m0_wen(m0_wen[0]), .m0_wdata(m0_wdata[0]),
    .m0_rdata(m0_rdata_o[0]), .m0_ack(m0_ack_o[0]),
    .m1_req(m1_req[0]), .m1_addr(m1_addr[0]), .m1_wen(m1_wen[0]), .m1_wdata(m1_wdata[0]),
    .m1_rdata(m1_rdata_o[0]), .m1_ack(m1_ack_o[0]),
    .Bus_addr(bus_addr_o[0]), .Bus_wen(bus_wen_o[0]), .Bus_wdata(bus_wdata_o[0]),
    .Bus_rdata(bus_rdata[0]), .busy(busy_o[0]), .gnt_id(gnt_o[0])
  );

  bus_arbiter #(.LAT(3), .AW(32), .DW(32)) u_lat3 (
    .clk_i(clk), .rst_i(rst_n),
    .m0_req(m0_req[1]), .m0_addr(m0_addr[1]), .m0_wen(m0_wen[1]), .m0_wdata(m0_wdata[1]),
    .m0_rdata(m0_rdata_o[1]), .m0_ack(m0_ack_o[1]),
    .m1_req(m1_req[1]), .m1_addr(m1_addr[1]), .m1_wen(m1_wen[1]), .m1_wdata(m1_wdata[1]),
    .m1_rdata(m1_rdata_o[1]), .m1_ack(m1_ack_o[1]),
    .Bus_addr(bus_addr_o[1]), .Bus_wen(bus_wen_o[1]), .Bus_wdata(bus_wdata_o[1]),
    .Bus_rdata(bus_rdata[1]), .busy(busy_o[1]), .gnt_id(gnt_o[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: a granted transfer lives for LAT+1 cycles after the grant
  // edge (cycles 1..LAT are the access, cycle LAT+1 is the ack), then one idle cycle.
  bit          md_act[2], md_g[2], md_prio[2], md_wen[2];
  int          md_k[2];
  logic [31:0] md_addr[2], md_wdata[2], md_rd[2];

  always @(posedge clk or negedge rst_n) begin
    bit w;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        md_act[d] = 0; md_g[d] = 0; md_prio[d] = 0; md_wen[d] = 0; md_k[d] = 0;
        md_addr[d] = 0; md_wdata[d] = 0; md_rd[d] = 0;
      end else if (md_act[d]) begin
        if (md_k[d] == lat_of(d) + 1) begin
          md_act[d] = 0;
          md_prio[d] = ~md_g[d];
          md_k[d] = 0;
        end else begin
          if (md_k[d] == lat_of(d)) md_rd[d] = bus_rdata[d];
          md_k[d]++;
        end
      end else if (m0_req[d] || m1_req[d]) begin
        w = (m0_req[d] && m1_req[d]) ? md_prio[d] : m1_req[d];
        md_act[d] = 1;
        md_k[d] = 1;
        md_g[d] = w;
        md_addr[d]  = w ? m1_addr[d]  : m0_addr[d];
        md_wdata[d] = w ? m1_wdata[d] : m0_wdata[d];
        md_wen[d]   = w ? m1_wen[d]   : m0_wen[d];
      end
    end
  end

  int g1_id[$];
  int g1_cyc[$];
  int wen_cnt1 = 0;
  bit prev_busy1 = 0;

  always @(negedge clk) begin
    bit ackx;
    for (int d = 0; d < 2; d++) begin
      ackx = md_act[d] && (md_k[d] == lat_of(d) + 1);
      chk($sformatf("busy[%0d]", d), busy_o[d], md_act[d]);
      chk($sformatf("gnt_id[%0d]", d), gnt_o[d], md_g[d]);
      chk($sformatf("bus_addr[%0d]", d), bus_addr_o[d], md_act[d] ? md_addr[d] : 0);
      chk($sformatf("bus_wdata[%0d]", d), bus_wdata_o[d], md_act[d] ? md_wdata[d] : 0);
      chk($sformatf("bus_wen[%0d]", d), bus_wen_o[d], md_act[d] && md_k[d] == 1 && md_wen[d]);
      chk($sformatf("m0_ack[%0d]", d), m0_ack_o[d], ackx && !md_g[d]);
      chk($sformatf("m1_ack[%0d]", d), m1_ack_o[d], ackx && md_g[d]);
      chk($sformatf("m0_rdata[%0d]", d), m0_rdata_o[d], (ackx && !md_g[d]) ? md_rd[d] : 0);
      chk($sformatf("m1_rdata[%0d]", d), m1_rdata_o[d], (ackx && md_g[d]) ? md_rd[d] : 0);
    end
    if (busy_o[1] && !prev_busy1) begin
      g1_id.push_back(int'(gnt_o[1]));
      g1_cyc.push_back(cyc);
    end
    prev_busy1 = busy_o[1];
    if (bus_wen_o[1]) wen_cnt1++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input int d, input int m, output int ack_cyc);
    int n;
    bit got;
    n = 0;
    got = 0;
    while (!got && n < 40) begin
      step();
      n++;
      got = (m == 0) ? m0_ack_o[d] : m1_ack_o[d];
    end
    ack_cyc = cyc;
    chk($sformatf("ack_seen d%0d m%0d", d, m), got, 1);
  endtask

  initial begin
    int c0, ca, acks, n;
    int exp_order[6];
    exp_order = '{0, 1, 0, 1, 0, 1};
    for (int d = 0; d < 2; d++) begin
      m0_req[d] = 0; m1_req[d] = 0; m0_wen[d] = 0; m1_wen[d] = 0;
      m0_addr[d] = 0; m1_addr[d] = 0; m0_wdata[d] = 0; m1_wdata[d] = 0; bus_rdata[d] = 0;
    end

    // Reset held with both requests pending: everything stays at zero.
    m0_req[0] = 1; m1_req[0] = 1; m0_addr[0] = 32'h100; m1_addr[0] = 32'h200;
    repeat (3) step();
    chk("rst_busy", busy_o[0], 0);
    chk("rst_ack", m0_ack_o[0], 0);
    chk("rst_addr", bus_addr_o[0], 0);
    rst_n = 1;
    step();
    chk("first_gnt", gnt_o[0], 0);
    chk("first_addr", bus_addr_o[0], 32'h100);
    wait_ack(0, 0, ca); step(); m0_req[0] = 0;
    wait_ack(0, 1, ca); step(); m1_req[0] = 0;
    step();

    // M0 read, LAT=1.
    bus_rdata[0] = 32'hDEAD_BEEF;
    m0_addr[0] = 32'h8000_0010; m0_wen[0] = 0; m0_req[0] = 1;
    c0 = cyc;
    wait_ack(0, 0, ca);
    chk("lat1_req2ack", ca - c0, 2);
    chk("lat1_rdata", m0_rdata_o[0], 32'hDEAD_BEEF);
    chk("lat1_m1ack", m1_ack_o[0], 0);
    step(); m0_req[0] = 0;
    step();

    // M1 write, LAT=3.
    wen_cnt1 = 0;
    bus_rdata[1] = 32'h5555_AAAA;
    m1_addr[1] = 32'hFFFF_F000; m1_wdata[1] = 32'h1234; m1_wen[1] = 1; m1_req[1] = 1;
    wait_ack(1, 1, ca);
    chk("lat3_grant2ack", ca - g1_cyc[g1_cyc.size()-1], 3);
    step(); m1_req[1] = 0; m1_wen[1] = 0;
    repeat (2) step();
    chk("lat3_wen_pulses", wen_cnt1, 1);

    // Contention: both masters hold requests for six transfers.
    g1_id.delete(); g1_cyc.delete();
    m0_addr[1] = 32'hA0; m1_addr[1] = 32'hB0; m0_req[1] = 1; m1_req[1] = 1;
    acks = 0; n = 0;
    while (acks < 6 && n < 200) begin
      step();
      n++;
      if (m0_ack_o[1] || m1_ack_o[1]) acks++;
    end
    chk("cont_acks", acks, 6);
    step(); m0_req[1] = 0; m1_req[1] = 0;
    repeat (3) step();
    chk("cont_grants", g1_id.size(), 6);
    for (int i = 0; i < 6 && i < g1_id.size(); i++) begin
      chk($sformatf("cont_order%0d", i), g1_id[i], exp_order[i]);
      if (i > 0) chk($sformatf("cont_spacing%0d", i), g1_cyc[i] - g1_cyc[i-1], 5);
    end

    // Address change during XFER is not seen on the bus.
    m0_addr[1] = 32'h1111_0000; m0_req[1] = 1;
    step();
    m0_addr[1] = 32'h2222_0000;
    step();
    chk("stable_addr_a", bus_addr_o[1], 32'h1111_0000);
    step();
    chk("stable_addr_b", bus_addr_o[1], 32'h1111_0000);
    wait_ack(1, 0, ca); step(); m0_req[1] = 0;
    step();

    // Abort an M1 write mid-transfer (prio is 1 at this point).
    m1_addr[1] = 32'hC0; m1_wdata[1] = 32'h77; m1_wen[1] = 1; m1_req[1] = 1;
    step();
    chk("abort_pre_wen", bus_wen_o[1], 1);
    rst_n = 0;
    #1;
    chk("abort_busy", busy_o[1], 0);
    chk("abort_wen", bus_wen_o[1], 0);
    m1_req[1] = 0; m1_wen[1] = 0;
    repeat (2) begin
      step();
      chk("abort_no_ack", m1_ack_o[1], 0);
    end
    rst_n = 1;
    m0_addr[1] = 32'hD0; m1_addr[1] = 32'hE0; m0_req[1] = 1; m1_req[1] = 1;
    step();
    chk("abort_prio_reset", gnt_o[1], 0);
    wait_ack(1, 0, ca); step(); m0_req[1] = 0;
    wait_ack(1, 1, ca); step(); m1_req[1] = 0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
